// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped timer/counter: register offsets,
// CTRL field layout, MODE encodings and FSM state encodings.
package timer_counter_pkg;

  // Byte offsets inside the 16-byte register window
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PRESET = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;
  localparam logic [3:0] OFF_RSVD   = 4'hC;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // MODE encodings; 2'b1x behaves like one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  // Stored CTRL fields, packed in register bit order {IM, MODE, EN}
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  // CTRL as seen on the bus: upper bits always read 0
  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    return {28'h0, c};
  endfunction

  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Data-bus slice seen by the timer: M-stage address/byte-enables/write data
// in, combinational read data and interrupt request out.
//
// Bus protocol: there is no valid/ready pair. A write is a one-cycle strobe
// that is accepted on the rising edge when the address hits the window and
// byteen == 4'b1111; any other byteen value (including 4'b0000) is no write.
// Reads are combinational on addr, and the slave never stalls the master.
interface timer_counter_if;
  import timer_counter_pkg::*;

  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output addr, byteen, wdata,
    input  rdata, irq
  );

  modport slave (
    input  addr, byteen, wdata,
    output rdata, irq
  );

endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Registers: CTRL (EN/MODE/IM), PRESET, COUNT (read-only), reserved word.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic           clk,
  input  logic           reset,
  timer_counter_if.slave bus,
  output logic [1:0]     dbg_state
);

  logic        hit;
  logic [3:0]  reg_off;
  logic        wr_en;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        unused_addr_lsb;

  ctrl_t       ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  logic [1:0]  state;

  // Address decode: byte lane bits addr[1:0] play no part
  assign hit             = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign reg_off         = {bus.addr[3:2], 2'b00};
  assign unused_addr_lsb = ^bus.addr[1:0];

  // Only full-word writes are accepted; COUNT and the reserved word ignore writes
  assign wr_en     = hit && (bus.byteen == 4'b1111);
  assign wr_ctrl   = wr_en && (reg_off == OFF_CTRL);
  assign wr_preset = wr_en && (reg_off == OFF_PRESET);

  // Timer FSM plus register writes; the CTRL write is placed last so that it
  // overrides the FSM's EN clear and irq_flag updates on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      preset   <= 32'h0;
      count    <= 32'h0;
      irq_flag <= 1'b0;
      state    <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl.en) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl.en) begin
            state <= ST_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            // PRESET of 0 lands here too, so it behaves like PRESET of 1
            count    <= 32'h0;
            irq_flag <= 1'b1;
            state    <= ST_INT;
          end
        end
        ST_INT: begin
          if (is_reload(ctrl.mode)) irq_flag <= 1'b0;
          else                      ctrl.en  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (wr_preset) preset <= bus.wdata;

      if (wr_ctrl) begin
        ctrl.en   <= bus.wdata[CTRL_EN_BIT];
        ctrl.mode <= bus.wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
        ctrl.im   <= bus.wdata[CTRL_IM_BIT];
        irq_flag  <= 1'b0;
      end
    end
  end

  // Zero-latency read mux; misses and the reserved word read as 0
  always_comb begin
    bus.rdata = 32'h0;
    if (hit) begin
      case (reg_off)
        OFF_CTRL:   bus.rdata = ctrl_word(ctrl);
        OFF_PRESET: bus.rdata = preset;
        OFF_COUNT:  bus.rdata = count;
        default:    bus.rdata = 32'h0;
      endcase
    end
  end

  assign bus.irq   = irq_flag & ctrl.im;
  assign dbg_state = state;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: register-access vector table, hand-written
// timing sequences, and randomized runs against a timeline model.
module tb_timer_counter;
  import timer_counter_pkg::*;

  localparam logic [31:0] BASE     = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_PRESET = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;
  localparam logic [31:0] A_RSVD   = BASE + 32'hC;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  timer_counter_if bus ();

  timer_counter #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_q[$];   // {irq, count} per clock edge

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus.byteen = 4'h0;
    tick();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.addr   = a;
    bus.wdata  = d;
    bus.byteen = be;
    tick();
    bus.byteen = 4'h0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.addr   = a;
    bus.byteen = 4'h0;
    #1;
    check(name, bus.rdata, exp);
  endtask

  // ---------------- register-access vector table ----------------
  typedef struct {
    logic        do_wr;
    logic [31:0] waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  // ---------------- random-run variables ----------------
  int unsigned p, newp, mode, im, len, pe, w, d;
  bit          chg, dis;
  int          m_e, m_p, m_preset, m_count, k, mpe;
  bit          m_flag, m_en, m_stop, reload;
  logic [32:0] e;
  logic [31:0] ctrl_v;

  initial begin
    reset      = 1'b1;
    bus.addr   = 32'h0;
    bus.byteen = 4'h0;
    bus.wdata  = 32'h0;
    tick();
    tick();
    reset = 1'b0;

    // ---- reset state ----
    rd_check("rst_ctrl",   A_CTRL,   32'h0);
    rd_check("rst_preset", A_PRESET, 32'h0);
    rd_check("rst_count",  A_COUNT,  32'h0);
    rd_check("rst_rsvd",   A_RSVD,   32'h0);
    check("rst_irq",   bus.irq,   32'h0);
    check("rst_state", dbg_state, ST_IDLE);

    // ---- vector table: decode, partial writes, read-only, reserved ----
    vecs[0]  = '{1'b1, A_PRESET,        4'hF, 32'h1234_5678, A_PRESET,        32'h1234_5678};
    vecs[1]  = '{1'b1, A_PRESET,        4'h3, 32'hDEAD_BEEF, A_PRESET,        32'h1234_5678};
    vecs[2]  = '{1'b1, A_PRESET,        4'hE, 32'hDEAD_BEEF, A_PRESET,        32'h1234_5678};
    vecs[3]  = '{1'b1, A_PRESET,        4'h0, 32'hDEAD_BEEF, A_PRESET,        32'h1234_5678};
    vecs[4]  = '{1'b1, A_COUNT,         4'hF, 32'h0000_FFFF, A_COUNT,         32'h0};
    vecs[5]  = '{1'b1, A_RSVD,          4'hF, 32'hFFFF_FFFF, A_RSVD,          32'h0};
    vecs[6]  = '{1'b1, A_CTRL,          4'hF, 32'hFFFF_FFF6, A_CTRL,          32'h6};
    vecs[7]  = '{1'b0, 32'h0,           4'h0, 32'h0,         BASE + 32'h3,    32'h6};
    vecs[8]  = '{1'b1, BASE + 32'h10,   4'hF, 32'h1,         A_CTRL,          32'h6};
    vecs[9]  = '{1'b0, 32'h0,           4'h0, 32'h0,         BASE + 32'h10,   32'h0};
    vecs[10] = '{1'b1, BASE + 32'h6,    4'hF, 32'h55,        A_PRESET,        32'h55};
    vecs[11] = '{1'b0, 32'h0,           4'h0, 32'h0,         BASE ^ 32'h8000_0000, 32'h0};
    vecs[12] = '{1'b1, A_CTRL,          4'hF, 32'h0,         A_CTRL,          32'h0};
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdata, vecs[i].be);
      rd_check($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
    end

    // ---- one-shot, PRESET=5 ----
    do_reset();
    wr(A_PRESET, 32'd5, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);               // edge 0
    check("s1_state_e0", dbg_state, ST_IDLE);
    bus.addr = A_COUNT;
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t == 1) check("s1_load_e1", dbg_state, ST_LOAD);
      check($sformatf("s1_count_e%0d", t), bus.rdata, (t < 2) ? 0 : ((t <= 6) ? 7 - t : 0));
      check($sformatf("s1_irq_e%0d", t), bus.irq, (t == 7) ? 1 : 0);
    end
    tick();                                 // edge 8
    rd_check("s1_ctrl_en_clr", A_CTRL, 32'h8);
    for (int t = 0; t < 3; t++) begin
      tick();
      check("s1_irq_held", bus.irq, 32'h1);
    end
    wr(A_CTRL, 32'h8, 4'hF);
    check("s1_irq_cleared", bus.irq, 32'h0);

    // ---- auto-reload, PRESET=2: pulse every 5 cycles ----
    do_reset();
    wr(A_PRESET, 32'd2, 4'hF);
    wr(A_CTRL, 32'hB, 4'hF);
    bus.addr = A_COUNT;
    for (int t = 1; t <= 20; t++) begin
      tick();
      check($sformatf("s2_irq_e%0d", t), bus.irq, (t % 5 == 4) ? 1 : 0);
      if (t % 5 == 2) check($sformatf("s2_reload_e%0d", t), bus.rdata, 32'd2);
    end
    wr(A_CTRL, 32'h0, 4'hF);

    // ---- partial write and masking ----
    do_reset();
    wr(A_PRESET, 32'd7, 4'hF);
    wr(A_PRESET, 32'h99, 4'b0011);
    rd_check("s3_partial", A_PRESET, 32'd7);
    wr(A_COUNT, 32'h1234, 4'hF);
    rd_check("s3_count_ro", A_COUNT, 32'h0);
    rd_check("s3_rsvd", A_RSVD, 32'h0);
    wr(A_PRESET, 32'd1, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);                // EN, one-shot, IM=0
    bus.addr = A_COUNT;
    for (int t = 1; t <= 6; t++) begin
      tick();
      check($sformatf("s3_masked_e%0d", t), bus.irq, 32'h0);
    end
    rd_check("s3_count_done", A_COUNT, 32'h0);
    rd_check("s3_en_cleared", A_CTRL, 32'h0);

    // ---- disable mid-count ----
    do_reset();
    wr(A_PRESET, 32'd10, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    bus.addr = A_COUNT;
    for (int t = 1; t <= 6; t++) tick();
    check("s4_count6", bus.rdata, 32'd6);
    wr(A_CTRL, 32'h8, 4'hF);                // edge 7, FSM still sees EN=1
    rd_check("s4_count_e7", A_COUNT, 32'd5);
    tick();
    check("s4_idle", dbg_state, ST_IDLE);
    for (int t = 0; t < 4; t++) begin
      tick();
      check("s4_held", bus.rdata, 32'd5);
      check("s4_no_irq", bus.irq, 32'h0);
    end

    // ---- reset mid-count ----
    do_reset();
    wr(A_PRESET, 32'd10, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    bus.addr = A_COUNT;
    for (int t = 1; t <= 9; t++) tick();
    check("s5_count3", bus.rdata, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_check("s5_ctrl",   A_CTRL,   32'h0);
    rd_check("s5_preset", A_PRESET, 32'h0);
    rd_check("s5_count",  A_COUNT,  32'h0);
    check("s5_irq",   bus.irq,   32'h0);
    check("s5_state", dbg_state, ST_IDLE);
    for (int t = 0; t < 5; t++) begin
      tick();
      check("s5_no_count", bus.rdata, 32'h0);
      check("s5_stay_idle", dbg_state, ST_IDLE);
    end

    // ---- PRESET=0 one-shot: irq at edge 3 ----
    do_reset();
    wr(A_PRESET, 32'd0, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    bus.addr = A_COUNT;
    for (int t = 1; t <= 3; t++) begin
      tick();
      check($sformatf("s6a_irq_e%0d", t), bus.irq, (t == 3) ? 1 : 0);
      check($sformatf("s6a_count_e%0d", t), bus.rdata, 32'h0);
    end

    // ---- CTRL write coinciding with INT ----
    do_reset();
    wr(A_PRESET, 32'd2, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    bus.addr = A_COUNT;
    for (int t = 1; t <= 4; t++) tick();
    check("s6b_irq_e4", bus.irq, 32'h1);
    wr(A_CTRL, 32'h9, 4'hF);                // edge 5, FSM in INT
    rd_check("s6b_en_kept", A_CTRL, 32'h9);
    check("s6b_irq_clr", bus.irq, 32'h0);
    check("s6b_idle", dbg_state, ST_IDLE);
    bus.addr = A_COUNT;
    for (int t = 6; t <= 9; t++) begin
      tick();
      check($sformatf("s6b_rerun_irq_e%0d", t), bus.irq, (t == 9) ? 1 : 0);
    end
    wr(A_CTRL, 32'h0, 4'hF);

    // ---- randomized runs against a timeline model ----
    for (int it = 0; it < 40; it++) begin
      do_reset();
      p    = $urandom_range(0, 9);
      mode = $urandom_range(0, 3);
      im   = $urandom_range(0, 1);
      pe   = (p == 0) ? 1 : p;
      len  = $urandom_range(pe + 4, 3 * pe + 14);
      chg  = (pe >= 2) && ($urandom_range(0, 1) == 1);
      w    = chg ? $urandom_range(3, pe + 1) : 0;
      newp = $urandom_range(0, 9);
      dis  = ($urandom_range(0, 3) == 0);
      d    = dis ? $urandom_range(2, pe + 1) : 0;
      if (dis && chg && d == w) dis = 1'b0;
      reload = (mode == 1);

      // Model: a run is a sequence of periods of PRESET_eff+3 edges starting
      // at the enabling edge; COUNT=P at offset 2, decrements by one per edge,
      // reaches 0 with the flag set at offset P_eff+2, then one-shot drops EN
      // (flag stays) or auto-reload drops the flag and starts a new period.
      m_e = 0; m_p = int'(p); m_preset = int'(p); m_count = 0;
      m_flag = 1'b0; m_en = 1'b1; m_stop = 1'b0;
      for (int t = 1; t <= int'(len); t++) begin
        if (chg && t == int'(w)) m_preset = int'(newp);
        if (!m_stop) begin
          k   = t - m_e;
          mpe = (m_p == 0) ? 1 : m_p;
          if (k >= 2 && k <= mpe + 1) begin
            m_count = m_p - (k - 2);
          end else if (k == mpe + 2) begin
            m_count = 0;
            m_flag  = 1'b1;
          end else if (k == mpe + 3) begin
            if (reload) begin
              m_flag = 1'b0;
              m_e    = t;
              m_p    = m_preset;
            end else begin
              m_en   = 1'b0;
              m_stop = 1'b1;
            end
          end
          if (dis && t == int'(d)) begin
            m_en   = 1'b0;
            m_stop = 1'b1;
          end
        end
        exp_q.push_back({m_flag & im[0], 32'(m_count)});
      end

      wr(A_PRESET, p, 4'hF);
      ctrl_v = {28'h0, im[0], mode[1:0], 1'b1};
      wr(A_CTRL, ctrl_v, 4'hF);
      for (int t = 1; t <= int'(len); t++) begin
        if (chg && t == int'(w)) begin
          bus.addr = A_PRESET; bus.wdata = newp; bus.byteen = 4'hF;
        end else if (dis && t == int'(d)) begin
          bus.addr = A_CTRL; bus.wdata = {28'h0, im[0], mode[1:0], 1'b0}; bus.byteen = 4'hF;
        end else begin
          bus.byteen = 4'h0;
        end
        tick();
        bus.byteen = 4'h0;
        bus.addr   = A_COUNT;
        #1;
        e = exp_q.pop_front();
        check($sformatf("rnd%0d_count_e%0d", it, t), bus.rdata, e[31:0]);
        check($sformatf("rnd%0d_irq_e%0d", it, t), bus.irq, {31'h0, e[32]});
      end
      rd_check($sformatf("rnd%0d_ctrl", it), A_CTRL, {28'h0, im[0], mode[1:0], m_en});
    end

    // ---- report ----
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_7F00, word-aligned base address of the 16-byte register window.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 addr  input  32  data-bus byte address from the M stage (m_data_addr).
REQ-005 byteen  input  4  write byte enables from the M stage (m_data_byteen); 4'b0000 means no write.
REQ-006 wdata  input  32  write data (m_data_wdata).
REQ-007 rdata  output  32  combinational read data for addr.
REQ-008 irq  output  1  interrupt request to the CPU.

Function
REQ-009 The block SHALL decode a hit when addr[31:4] == BASE_ADDR[31:4]; addr[1:0] is ignored.
REQ-010 The register map SHALL be offset 0x0 CTRL, 0x4 PRESET, 0x8 COUNT (read-only), 0xC reserved (reads 0, writes ignored).
REQ-011 CTRL SHALL store only [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM; bits [31:4] SHALL read 0.
REQ-012 A write SHALL take effect only on hit with byteen == 4'b1111; partial writes SHALL be ignored entirely.
REQ-013 rdata SHALL equal the addressed register on hit, else 32'h0, with no latency.
REQ-014 The FSM SHALL have states IDLE, LOAD, CNT, INT.
REQ-015 IDLE: if EN == 1, go to LOAD; otherwise stay.
REQ-016 LOAD: COUNT <= PRESET; go to CNT.
REQ-017 CNT: if EN == 0, go to IDLE with COUNT held; else if COUNT > 1, COUNT <= COUNT - 1; else COUNT <= 0, irq_flag <= 1, go to INT.
REQ-018 INT with MODE one-shot: EN <= 0, irq_flag held; go to IDLE.
REQ-019 INT with MODE auto-reload: irq_flag <= 0 and EN held; go to IDLE, giving a one-cycle irq pulse and a reload period of PRESET+3 cycles (PRESET >= 1).
REQ-020 irq SHALL equal irq_flag & IM.
REQ-021 Any accepted CTRL write SHALL clear irq_flag.
REQ-022 On the same edge, a software write to CTRL SHALL win over the FSM's EN clear in INT.
REQ-023 PRESET written during CNT SHALL NOT affect COUNT until the next LOAD.
REQ-024 PRESET == 0 SHALL behave as PRESET == 1: INT is entered one CNT cycle after LOAD.
REQ-025 COUNT SHALL never wrap below 0.

Reset
REQ-026 On reset, CTRL, PRESET, COUNT and irq_flag SHALL clear to 0, and the state SHALL be IDLE.
REQ-027 Reset SHALL also apply in any state mid-count.
REQ-028 After reset, irq SHALL be 0 and rdata SHALL be 0 for every address.

Structure
REQ-029 A shared package SHALL hold the register offsets, the CTRL bit positions, the MODE encodings and the FSM state encodings.
REQ-030 The block SHALL be a single module with no sub-module.
REQ-031 A bridge upstream SHALL route reads through rdata; that routing is outside this block.

Verification
REQ-032 Bench scenario 1, one-shot:
- Stimulus: write PRESET=5, then at edge 0 write CTRL=4'b1001.
- Response: LOAD at edge 1; COUNT=5 at edge 2, then 4,3,2,1 at edges 3-6; COUNT=0 and irq=1 at edge 7; CTRL[0]=0 at edge 8; irq stays 1 until a CTRL write.
REQ-033 Bench scenario 2, auto-reload:
- Stimulus: PRESET=2, CTRL=4'b1011.
- Response: irq is a one-cycle pulse every 5 cycles; COUNT reloads to 2 each period.
REQ-034 Bench scenario 3, partial write and masking:
- byteen=4'b0011 write to PRESET leaves PRESET unchanged.
- A write to COUNT is ignored.
- Offset 0xC reads 0.
- With IM=0, irq stays 0 while the internal flag is set.
REQ-035 Bench scenario 4, disable mid-count:
- Stimulus: PRESET=10; clear EN when COUNT=6.
- Response: FSM returns to IDLE with COUNT held at 6 or 5 (per the edge); no irq.
REQ-036 Bench scenario 5, reset mid-count:
- Stimulus: assert reset while COUNT=3.
- Response: next edge gives all registers 0, IDLE, irq=0, and no further counting.
REQ-037 Bench scenario 6, edge cases:
- PRESET=0 one-shot: irq at edge 3 after the enabling write.
- A CTRL write coinciding with INT keeps the written EN and clears irq.
